result_writer_rgb888: RTL

Write-side counterpart of the 3x3 window reader. It accepts the convolution engine's per-pixel R/G/B accumulator results and normalises/saturates each channel to 8 bits. It buffers pixels in a 2-entry FIFO and writes them in raster order into the output frame BRAM. It throttles the MAC with oBusy and signals frame completion.

---
 rtl/conv_pkg.sv | 38 +++
 rtl/pix_fifo2.sv | 60 ++++++
 rtl/result_writer_rgb888.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : conv_pkg
// Purpose  : Shared types, frame defaults and channel saturation helper for
//            the convolution window reader / result writer pair.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package conv_pkg;

    localparam int c_FRAME_WIDTH  = 480;
    localparam int c_FRAME_HEIGHT = 272;
    localparam int c_FRAME_DEPTH  = c_FRAME_WIDTH * c_FRAME_HEIGHT;
    localparam int c_ACC_W        = 20;
    localparam int c_SHIFT        = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Arithmetic shift (floor for negatives) followed by clamp to 0..255.
    // The accumulator is passed sign-extended to 32 bits so one helper serves
    // any accumulator width up to 32.
    function automatic logic [7:0] sat_u8(input logic signed [31:0] acc,
                                          input int                 shift);
        logic signed [31:0] v;
        v = acc >>> shift;
        if (v < 0)
            return 8'd0;
        else if (v > 32'sd255)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pix_fifo2.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pix_fifo2
// Purpose  : Two-entry synchronous FIFO holding converted pixels between the
//            MAC result interface and the BRAM write port.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module pix_fifo2 #(
    parameter int DATA_W = 24
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iPush,
    input  logic [DATA_W-1:0] iData,
    input  logic              iPop,
    output logic [DATA_W-1:0] oHead,
    output logic              oFull,
    output logic              oEmpty,
    output logic [1:0]        oCount
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_q, rd_q;
    logic [1:0]        count_q;
    logic              w_push, w_pop;

    // Guard against pushing into a full FIFO or popping an empty one.
    assign w_push = iPush && (count_q != 2'd2);
    assign w_pop  = iPop  && (count_q != 2'd0);

    assign oHead  = mem_q[rd_q];
    assign oFull  = (count_q == 2'd2);
    assign oEmpty = (count_q == 2'd0);
    assign oCount = count_q;

    // Storage, pointers and occupancy; simultaneous push/pop keeps the count.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (w_push) begin
                mem_q[wr_q] <= iData;
                wr_q        <= ~wr_q;
            end
            if (w_pop)
                rd_q <= ~rd_q;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_writer_rgb888.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : result_writer_rgb888
// Purpose  : Converts signed per-channel accumulators to RGB888, buffers them
//            in a 2-entry FIFO and writes them in raster order to frame BRAM.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module result_writer_rgb888
    import conv_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 17,
    parameter int WIDTH  = c_FRAME_WIDTH,
    parameter int HEIGHT = c_FRAME_HEIGHT,
    parameter int DEPTH  = WIDTH * HEIGHT,
    parameter int ACC_W  = c_ACC_W,
    parameter int SHIFT  = c_SHIFT
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iEn,
    input  logic              iValid,
    input  logic [ACC_W-1:0]  iAccR,
    input  logic [ACC_W-1:0]  iAccG,
    input  logic [ACC_W-1:0]  iAccB,
    output logic              oBusy,
    input  logic              iGrant,
    output logic              oCs,
    output logic              oWe,
    output logic [ADDR_W-1:0] oAddr,
    output logic [DATA_W-1:0] oPixel,
    output logic              oFrameDone,
    output logic              oOverflow
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [DATA_W-1:0] last_pix_q, last_pix_d;
    logic              ovf_q, ovf_d;

    logic              w_busy, w_push, w_write, w_drop;
    logic              w_fifo_full, w_empty;
    logic [1:0]        w_count;
    logic [DATA_W-1:0] w_pix_in, w_head;

    // Channel conversion is purely combinational so a push lands this edge.
    assign w_pix_in = {sat_u8(32'(signed'(iAccR)), SHIFT),
                       sat_u8(32'(signed'(iAccG)), SHIFT),
                       sat_u8(32'(signed'(iAccB)), SHIFT)};

    // Busy comes straight from the occupancy so a full FIFO blocks the same
    // cycle, even if a pop is freeing a slot.
    assign w_busy  = (state_q != ST_RUN) || (w_count == 2'd2) || !iEn;
    assign w_push  = iEn && iValid && !w_busy;
    assign w_drop  = iValid && w_busy;
    assign w_write = (state_q == ST_RUN) && iEn && !w_empty && iGrant;

    pix_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .iClk   (iClk),
        .iRst   (iRst),
        .iPush  (w_push),
        .iData  (w_pix_in),
        .iPop   (w_write),
        .oHead  (w_head),
        .oFull  (w_fifo_full),
        .oEmpty (w_empty),
        .oCount (w_count)
    );

    assert property (@(posedge iClk) disable iff (!iRst)
                     (w_fifo_full == (w_count == 2'd2)) && (w_empty == (w_count == 2'd0)));

    assign oBusy      = w_busy;
    assign oCs        = w_write;
    assign oWe        = w_write;
    assign oAddr      = w_write ? addr_q : last_addr_q;
    assign oPixel     = w_write ? w_head : last_pix_q;
    assign oFrameDone = (state_q == ST_DONE);
    assign oOverflow  = ovf_q;

    // State, address, sticky overflow and held BRAM bus registers.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            last_pix_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            last_pix_q  <= last_pix_d;
            ovf_q       <= ovf_d;
        end
    end

    // Frame sequencing: start on enable, finish after the last address write.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        last_pix_d  = last_pix_q;
        ovf_d       = ovf_q | w_drop;

        if (w_write) begin
            last_addr_d = addr_q;
            last_pix_d  = w_head;
        end

        case (state_q)
            ST_IDLE: begin
                if (iEn) begin
                    state_d = ST_RUN;
                    addr_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (w_write) begin
                    if (addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = ST_DONE;
                        addr_d  = '0;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
